// File: rtl/column_readout_pkg.sv
// column_readout_pkg: shared constants for the column readout stage.
// FSM state encodings, memory action codes shared with the event memory,
// and saturation bound helpers for the fixed-point to pixel conversion.
package column_readout_pkg;

    // Readout FSM states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Memory action codes; the clear-after-read pulse drives ACT_CLEAR
    typedef enum logic [1:0] {
        ACT_NONE       = 2'd0,
        ACT_ACCUMULATE = 2'd1,
        ACT_FILTER     = 2'd2,
        ACT_CLEAR      = 2'd3
    } mem_action_e;

    // Largest representable signed value of a w-bit pixel
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Smallest representable signed value of a w-bit pixel
    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/readout_skid_fifo.sv
// readout_skid_fifo: 2-entry first-word-fall-through FIFO with occupancy.
// The head entry is presented combinationally and stays put until popped.
// The caller guarantees no push when full and no pop when empty.
module readout_skid_fifo #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         valid_o,
    output logic [1:0]   count_o
);

    logic [1:0][W-1:0] mem_q, mem_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic [1:0]        count_q, count_d;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push_i) begin
            mem_d[wr_q] = din_i;
            wr_d        = ~wr_q;
        end
        if (pop_i) begin
            rd_d = ~rd_q;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers; storage cleared so the head reads zero after reset
    always_ff @(posedge clk) begin
        if (rst_i) begin
            mem_q   <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign dout_o  = mem_q[rd_q];
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/column_readout.sv
// column_readout: scans the column event memory on start and streams every
// address out as a saturated signed pixel frame (tuser = first, tlast = last)
// over a valid/ready interface with full backpressure.
// Optional feature macro COLUMN_READOUT_CLEAR_AFTER_READ_EN adds clr_o /
// clr_addr_o, pulsed the cycle after each accepted beat for destructive readout.
module column_readout
    import column_readout_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int n          = 16,
    parameter int SHIFT      = 4,
    parameter int OUT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] addrb_o,
    input  logic [n-1:0]          dob_i,
    output logic [OUT_WIDTH-1:0]  m_tdata_o,
    output logic                  m_tvalid_o,
    input  logic                  m_tready_i,
    output logic                  m_tuser_o,
`ifdef COLUMN_READOUT_CLEAR_AFTER_READ_EN
    output logic                  m_tlast_o,
    output logic                  clr_o,
    output logic [ADDR_WIDTH-1:0] clr_addr_o
`else
    output logic                  m_tlast_o
`endif
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic signed [n-1:0]   SAT_HI    = n'(sat_max(OUT_WIDTH));
    localparam logic signed [n-1:0]   SAT_LO    = n'(sat_min(OUT_WIDTH));
`ifdef COLUMN_READOUT_CLEAR_AFTER_READ_EN
    localparam int PW = ADDR_WIDTH + OUT_WIDTH + 2;
`else
    localparam int PW = OUT_WIDTH + 2;
`endif

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  inflight_q, inflight_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic signed [n-1:0]   shifted;
    logic [OUT_WIDTH-1:0]  pix;
    logic [PW-1:0]         fifo_din, fifo_dout;
    logic [1:0]            fifo_count;
    logic                  pop, head_last;
    logic [2:0]            used;

    // Arithmetic shift then clamp to the signed pixel range
    always_comb begin
        shifted = $signed(dob_i) >>> SHIFT;
        if (shifted > SAT_HI)      pix = SAT_HI[OUT_WIDTH-1:0];
        else if (shifted < SAT_LO) pix = SAT_LO[OUT_WIDTH-1:0];
        else                       pix = shifted[OUT_WIDTH-1:0];
    end

`ifdef COLUMN_READOUT_CLEAR_AFTER_READ_EN
    assign fifo_din = {rd_addr_q, rd_addr_q == '0, rd_addr_q == LAST_ADDR, pix};
`else
    assign fifo_din = {rd_addr_q == '0, rd_addr_q == LAST_ADDR, pix};
`endif

    readout_skid_fifo #(.W(PW)) u_fifo (
        .clk     (clk),
        .rst_i   (rst_i),
        .push_i  (inflight_q),
        .din_i   (fifo_din),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .valid_o (m_tvalid_o),
        .count_o (fifo_count)
    );

    assign pop       = m_tvalid_o & m_tready_i;
    assign m_tdata_o = fifo_dout[OUT_WIDTH-1:0];
    assign m_tlast_o = fifo_dout[OUT_WIDTH];
    assign m_tuser_o = fifo_dout[OUT_WIDTH+1];
    assign head_last = m_tlast_o;

    // Slots committed in the FIFO; a beat leaving this cycle frees its slot,
    // which is what lets a steady ready sustain one beat per cycle.
    assign used = {1'b0, fifo_count} + {2'b00, inflight_q};

    // FSM, read issue and frame bookkeeping
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rd_addr_d  = rd_addr_q;
        inflight_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // busy_q still high during the done cycle, so a start there is dropped
                if (start_i && !busy_q) begin
                    state_d = ST_SCAN;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_SCAN: begin
                if ((used - {2'b00, pop}) < 3'd2) begin
                    inflight_d = 1'b1;
                    rd_addr_d  = addr_q;
                    if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
                    else                     addr_d  = addr_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // The tlast beat is always the final one left in the FIFO
                if (pop && head_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (done_q) busy_d = 1'b0;
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rd_addr_q  <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_addr_q  <= rd_addr_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign addrb_o = addr_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

`ifdef COLUMN_READOUT_CLEAR_AFTER_READ_EN
    logic                  clr_q, clr_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

    // One clear per accepted beat, carrying that beat's stored address
    always_comb begin
        clr_d      = pop;
        clr_addr_d = pop ? fifo_dout[PW-1 -: ADDR_WIDTH] : clr_addr_q;
    end

    // Clear pulse registers
    always_ff @(posedge clk) begin
        if (rst_i) begin
            clr_q      <= 1'b0;
            clr_addr_q <= '0;
        end else begin
            clr_q      <= clr_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign clr_o      = clr_q;
    assign clr_addr_o = clr_addr_q;
`endif

endmodule

// File: tb/tb_column_readout.sv
// tb_column_readout: scoreboard bench for column_readout (ADDR_WIDTH=2).
// Stimulus pushes hand-computed beats into exp_q; a negedge monitor pops and
// compares every accepted beat, checks hold-while-stalled and read-ahead.
module tb_column_readout;

    localparam int AW = 2;
    localparam int DW = 16;
    localparam int OW = 8;

    typedef struct packed {
        logic [OW-1:0] d;
        logic          u;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_i, start_i, busy_o, done_o;
    logic [AW-1:0] addrb_o;
    logic [DW-1:0] dob_i;
    logic [OW-1:0] m_tdata_o;
    logic          m_tvalid_o, m_tready_i, m_tuser_o, m_tlast_o;
`ifdef COLUMN_READOUT_CLEAR_AFTER_READ_EN
    logic          clr_o;
    logic [AW-1:0] clr_addr_o;
`endif

    always #5 clk = ~clk;

    column_readout #(.ADDR_WIDTH(AW), .n(DW), .SHIFT(4), .OUT_WIDTH(OW)) dut (
        .clk        (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .addrb_o    (addrb_o),
        .dob_i      (dob_i),
        .m_tdata_o  (m_tdata_o),
        .m_tvalid_o (m_tvalid_o),
        .m_tready_i (m_tready_i),
        .m_tuser_o  (m_tuser_o),
`ifdef COLUMN_READOUT_CLEAR_AFTER_READ_EN
        .m_tlast_o  (m_tlast_o),
        .clr_o      (clr_o),
        .clr_addr_o (clr_addr_o)
`else
        .m_tlast_o  (m_tlast_o)
`endif
    );

    // Memory model: registered read, data one cycle after the address
    logic [DW-1:0] mem [0:3] = '{16'h0010, 16'h7FFF, 16'h8000, 16'hFFF0};
    always @(posedge clk) dob_i <= mem[addrb_o];

    // Hand-computed pixels: 1, 2047->127, -2048->-128, -1
    logic [OW-1:0] exp_pix [0:3] = '{8'h01, 8'h7F, 8'h80, 8'hFF};

    int    cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    n_chk = 0, n_fail = 0;
    beat_t exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ready driver: 0 always ready, 1 random 50%, 2 held low, 3 driven by stimulus
    int rmode = 0;
    initial begin
        m_tready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       m_tready_i = 1'b1;
                1:       m_tready_i = 1'($urandom_range(1, 0));
                2:       m_tready_i = 1'b0;
                default: ;
            endcase
        end
    end

    // Monitor
    beat_t cur, prev_b, e;
    logic  prev_stall = 1'b0, fv_seen = 1'b0;
    int    acc = 0, dn_cnt = 0, done_cyc = -1, last_hs = -1, fv_cyc = -1;
`ifdef COLUMN_READOUT_CLEAR_AFTER_READ_EN
    int    clr_a_q [$];
    int    clr_c_q [$];
    int    clr_cnt = 0;
`endif

    always @(negedge clk) begin
        if (rst_i) begin
            prev_stall = 1'b0;
            acc        = 0;
            fv_seen    = 1'b0;
`ifdef COLUMN_READOUT_CLEAR_AFTER_READ_EN
            clr_a_q.delete();
            clr_c_q.delete();
`endif
        end else begin
            cur = '{d: m_tdata_o, u: m_tuser_o, l: m_tlast_o};
            if (prev_stall) begin
                check("hold_valid", 32'(m_tvalid_o), 32'd1);
                check("hold_payload", 32'(cur), 32'(prev_b));
            end
            if (busy_o) check("read_ahead", 32'(int'(addrb_o) <= acc + 2), 32'd1);
            if (busy_o && m_tvalid_o && !fv_seen) begin
                fv_seen = 1'b1;
                fv_cyc  = cyc;
            end
`ifdef COLUMN_READOUT_CLEAR_AFTER_READ_EN
            if (clr_o) begin
                clr_cnt++;
                if (clr_a_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL clr_unexpected: got addr %0d expected no pulse", clr_addr_o);
                end else begin
                    check("clr_addr", 32'(clr_addr_o), 32'(clr_a_q.pop_front()));
                    check("clr_cycle", 32'(cyc), 32'(clr_c_q.pop_front()));
                end
            end
`endif
            if (m_tvalid_o && m_tready_i) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got 0x%0h expected no beat", cur);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 32'(cur), 32'(e));
                end
`ifdef COLUMN_READOUT_CLEAR_AFTER_READ_EN
                clr_a_q.push_back(acc);
                clr_c_q.push_back(cyc + 1);
`endif
                acc++;
                last_hs = cyc;
            end
            if (done_o) begin
                dn_cnt++;
                done_cyc = cyc;
            end
            prev_stall = m_tvalid_o && !m_tready_i;
            prev_b     = cur;
            if (!busy_o) begin
                acc     = 0;
                fv_seen = 1'b0;
            end
        end
    end

    int st_cyc = 0;

    task automatic push_frame();
        for (int i = 0; i < 4; i++) exp_q.push_back('{d: exp_pix[i], u: (i == 0), l: (i == 3)});
    endtask

    // start sampled on the edge that closes this cycle; st_cyc is the cycle after
    task automatic pulse_start();
        @(posedge clk);
        #1;
        start_i = 1'b1;
        st_cyc  = cyc + 1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int base);
        int k;
        k = 0;
        while (dn_cnt == base && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({name, "_done_seen"}, 32'(dn_cnt != base), 32'd1);
        repeat (8) @(posedge clk);
        #1;
        check({name, "_done_once"}, 32'(dn_cnt), 32'(base + 1));
        check({name, "_all_beats"}, 32'(exp_q.size()), 32'd0);
        check({name, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int base, k;
        rst_i   = 1'b1;
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Reset state
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_addrb", 32'(addrb_o), 32'd0);
        check("rst_tvalid", 32'(m_tvalid_o), 32'd0);
        check("rst_tdata", 32'(m_tdata_o), 32'd0);
        check("rst_tuser", 32'(m_tuser_o), 32'd0);
        check("rst_tlast", 32'(m_tlast_o), 32'd0);

        // Full-rate frame
        base = dn_cnt;
        push_frame();
        pulse_start();
        wait_done("t1", base);
        check("t1_start_latency", 32'(fv_cyc - st_cyc), 32'd2);
        check("t1_back_to_back", 32'(last_hs - fv_cyc), 32'd3);
        check("t1_done_after_last", 32'(done_cyc - last_hs), 32'd1);

        // Random backpressure
        rmode = 1;
        base  = dn_cnt;
        push_frame();
        pulse_start();
        wait_done("t2", base);
        rmode = 0;

        // Second start while busy is dropped
        base = dn_cnt;
        push_frame();
        pulse_start();
        k = 0;
        while (acc < 1 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("t3_beat0_seen", 32'(acc >= 1), 32'd1);
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_done("t3", base);
        repeat (20) @(posedge clk);
        #1;
        check("t3_no_restart", 32'(dn_cnt), 32'(base + 1));

        // Reset after beat 1 accepted aborts the frame
        rmode      = 3;
        m_tready_i = 1'b1;
        base       = dn_cnt;
        push_frame();
        pulse_start();
        k = 0;
        while (acc < 2 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("t4_two_beats", 32'(acc), 32'd2);
        m_tready_i = 1'b0;
        rst_i      = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        exp_q.delete();
        check("t4_tvalid_low", 32'(m_tvalid_o), 32'd0);
        check("t4_busy_low", 32'(busy_o), 32'd0);
        check("t4_addrb_zero", 32'(addrb_o), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("t4_no_done", 32'(dn_cnt), 32'(base));
        rmode = 0;
        push_frame();
        pulse_start();
        wait_done("t4b", base);

        // Consumer stalled right after start: only two reads may go out
        rmode = 2;
        base  = dn_cnt;
        push_frame();
        pulse_start();
        repeat (10) @(posedge clk);
        #1;
        check("t5_reads_issued", 32'(addrb_o), 32'd2);
        check("t5_valid", 32'(m_tvalid_o), 32'd1);
        check("t5_head", 32'({m_tdata_o, m_tuser_o, m_tlast_o}), 32'({8'h01, 1'b1, 1'b0}));
        rmode = 0;
        wait_done("t5", base);

`ifdef COLUMN_READOUT_CLEAR_AFTER_READ_EN
        // Destructive readout under random stalls: four clears, addresses 0..3
        rmode = 1;
        base  = dn_cnt;
        k     = clr_cnt;
        push_frame();
        pulse_start();
        wait_done("t6", base);
        rmode = 0;
        check("t6_clr_count", 32'(clr_cnt - k), 32'd4);
        check("t6_clr_pending", 32'(clr_a_q.size()), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
